// File: rtl/snk_food.sv
// Food placement and score keeper: picks a free cell via LFSR + linear probe, detects eats on step, counts score.
// Outputs registered; food valid 2 + collisions edges after reset/eat; no backpressure, steps outside WAIT are dropped.
module snk_food #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic [111:0] snk_bits,
    input  logic         step,
    input  logic         dead,
    output logic [5:0]   food,
    output logic         food_valid,
    output logic [3:0]   score,
    output logic         eaten,
    output logic         win
);

    typedef enum logic [1:0] {
        S_PLACE = 2'd0,
        S_CHECK = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [5:0]  cand_q, cand_d;
    logic [5:0]  food_q, food_d;
    logic        food_valid_q, food_valid_d;
    logic [3:0]  score_q, score_d;
    logic        eaten_q, eaten_d;
    logic        win_q, win_d;

    logic        cand_occ;
    logic        head_hit;
    logic [3:0]  score_inc;
    logic        lfsr_fb;

    // Candidate is occupied if any live segment sits on it.
    always_comb begin
        cand_occ = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (snk_bits[7*i+6] && (snk_bits[7*i +: 6] == cand_q)) begin
                cand_occ = 1'b1;
            end
        end
    end

    assign head_hit  = snk_bits[6] && (snk_bits[5:0] == food_q);
    assign score_inc = score_q + 4'd1;
    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cand_d       = cand_q;
        food_d       = food_q;
        food_valid_d = food_valid_q;
        score_d      = score_q;
        eaten_d      = 1'b0;
        win_d        = win_q;

        if (state_q != S_HALT) begin
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
        end

        // Dead outranks everything, including an eat in the same cycle.
        if (dead) begin
            state_d = S_HALT;
        end else begin
            case (state_q)
                S_PLACE: begin
                    cand_d       = lfsr_q[5:0];
                    food_valid_d = 1'b0;
                    state_d      = S_CHECK;
                end
                S_CHECK: begin
                    if (cand_occ) begin
                        cand_d = cand_q + 6'd1;
                    end else begin
                        food_d       = cand_q;
                        food_valid_d = 1'b1;
                        state_d      = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (step && head_hit) begin
                        eaten_d      = 1'b1;
                        score_d      = score_inc;
                        food_valid_d = 1'b0;
                        if (score_inc == 4'd15) begin
                            win_d   = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            state_d = S_PLACE;
                        end
                    end
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_PLACE;
            lfsr_q       <= SEED;
            cand_q       <= 6'd0;
            food_q       <= 6'd0;
            food_valid_q <= 1'b0;
            score_q      <= 4'd0;
            eaten_q      <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cand_q       <= cand_d;
            food_q       <= food_d;
            food_valid_q <= food_valid_d;
            score_q      <= score_d;
            eaten_q      <= eaten_d;
            win_q        <= win_d;
        end
    end

    assign food       = food_q;
    assign food_valid = food_valid_q;
    assign score      = score_q;
    assign eaten      = eaten_q;
    assign win        = win_q;

endmodule

// File: tb/tb_snk_food.sv
// Randomized bench for snk_food against an event-level model of placement, eating, win and dead.
module tb_snk_food;

    localparam logic [7:0] SEED = 8'hA5;

    logic         CLK = 1'b0;
    logic         rst_n;
    logic [111:0] snk_bits;
    logic         step;
    logic         dead;
    logic [5:0]   food;
    logic         food_valid;
    logic [3:0]   score;
    logic         eaten;
    logic         win;

    logic         seg_on   [16];
    logic [5:0]   seg_cell [16];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n;
    logic [5:0] food_m;
    int score_m;

    always #5 CLK = ~CLK;

    snk_food #(.SEED(SEED)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .snk_bits  (snk_bits),
        .step      (step),
        .dead      (dead),
        .food      (food),
        .food_valid(food_valid),
        .score     (score),
        .eaten     (eaten),
        .win       (win)
    );

    always_comb begin
        snk_bits = '0;
        for (int i = 0; i < 16; i++) begin
            snk_bits[7*i +: 7] = {seg_on[i], seg_cell[i]};
        end
    end

    // Edges since reset release; edge 1 is the first PLACE action.
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] v;
        v = SEED;
        for (int k = 0; k < n; k++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    function automatic logic occ_m(input logic [5:0] c);
        for (int i = 0; i < 16; i++)
            if (seg_on[i] && seg_cell[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic segs_off();
        for (int i = 0; i < 16; i++) begin
            seg_on[i]   = 1'b0;
            seg_cell[i] = 6'd0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Model: candidate = LFSR after (place_edge-1) shifts, probe upward to first free cell.
    task automatic place(input int place_edge);
        logic [7:0] lv;
        logic [5:0] c;
        int k;
        int vedge;
        lv = lfsr_at(place_edge - 1);
        c  = lv[5:0];
        k  = 0;
        while (occ_m(c)) begin
            c = c + 6'd1;
            k++;
        end
        vedge = place_edge + 1 + k;
        while (edge_n < vedge - 1) tick();
        check_eq("fv_before_place", 32'(food_valid), 32'd0);
        tick();
        check_eq("fv_after_place", 32'(food_valid), 32'd1);
        check_eq("food_cell", 32'(food), 32'(c));
        check_eq("food_free", 32'(occ_m(food)), 32'd0);
        food_m = c;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst_n = 1'b0;
        #1;
        check_eq("rst_score", 32'(score), 32'd0);
        check_eq("rst_win", 32'(win), 32'd0);
        check_eq("rst_fv", 32'(food_valid), 32'd0);
        check_eq("rst_food", 32'(food), 32'd0);
        check_eq("rst_eaten", 32'(eaten), 32'd0);
        step = 1'b0;
        dead = 1'b0;
        #1;
        rst_n = 1'b1;
        score_m = 0;
    endtask

    task automatic eat_round();
        int n;
        seg_on[0]   = 1'b1;
        seg_cell[0] = food_m;
        for (int i = 1; i < 16; i++) begin
            seg_on[i]   = (i <= score_m);
            seg_cell[i] = 6'($urandom_range(0, 63));
        end
        repeat ($urandom_range(0, 3)) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        n = edge_n;
        score_m++;
        check_eq("eat_pulse", 32'(eaten), 32'd1);
        check_eq("eat_score", 32'(score), 32'(score_m));
        check_eq("eat_fv_clr", 32'(food_valid), 32'd0);
        check_eq("eat_win", 32'(win), 32'(score_m == 15));
        if (score_m < 15) begin
            tick();
            check_eq("eat_pulse_end", 32'(eaten), 32'd0);
            place(n + 1);
        end
    endtask

    initial begin
        logic [5:0] hc;
        rst_n = 1'b0;
        step  = 1'b0;
        dead  = 1'b0;
        segs_off();
        food_m  = '0;
        score_m = 0;

        // First placement from reset, empty board.
        #12;
        check_eq("init_score", 32'(score), 32'd0);
        check_eq("init_fv", 32'(food_valid), 32'd0);
        check_eq("init_win", 32'(win), 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        place(1);
        check_eq("first_food", 32'(food), 32'h25);

        // Collision skip, with a step dropped during CHECK (head on cand).
        segs_off();
        seg_on[0] = 1'b1; seg_cell[0] = 6'b100101;
        seg_on[1] = 1'b1; seg_cell[1] = 6'b100110;
        seg_on[2] = 1'b1; seg_cell[2] = 6'b100111;
        do_reset();
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        check_eq("drop_step_eaten", 32'(eaten), 32'd0);
        tick();
        check_eq("drop_step_eaten2", 32'(eaten), 32'd0);
        check_eq("drop_step_score", 32'(score), 32'd0);
        place(1);
        check_eq("skip_food", 32'(food), 32'h28);

        eat_round();

        // Step with head away from food.
        hc = (food_m == 6'b001001) ? 6'b001010 : 6'b001001;
        seg_cell[0] = hc;
        step = 1'b1;
        tick();
        step = 1'b0;
        check_eq("miss_eaten", 32'(eaten), 32'd0);
        check_eq("miss_score", 32'(score), 32'(score_m));
        check_eq("miss_fv", 32'(food_valid), 32'd1);
        tick();
        check_eq("miss_food", 32'(food), 32'(food_m));

        while (score_m < 15) eat_round();
        check_eq("win_score", 32'(score), 32'd15);
        tick();
        check_eq("halt_eaten_clr", 32'(eaten), 32'd0);
        seg_on[0]   = 1'b1;
        seg_cell[0] = food;
        step = 1'b1;
        tick();
        step = 1'b0;
        check_eq("halt_step_eaten", 32'(eaten), 32'd0);
        check_eq("halt_step_score", 32'(score), 32'd15);
        check_eq("halt_win", 32'(win), 32'd1);

        // Dead beats a simultaneous eat.
        segs_off();
        do_reset();
        place(1);
        repeat (3) eat_round();
        seg_on[0]   = 1'b1;
        seg_cell[0] = food_m;
        step = 1'b1;
        dead = 1'b1;
        tick();
        step = 1'b0;
        check_eq("dead_eaten", 32'(eaten), 32'd0);
        check_eq("dead_score", 32'(score), 32'(score_m));
        check_eq("dead_fv", 32'(food_valid), 32'd1);
        check_eq("dead_food", 32'(food), 32'(food_m));
        repeat (3) tick();
        dead = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        check_eq("dead_frozen_eaten", 32'(eaten), 32'd0);
        check_eq("dead_frozen_score", 32'(score), 32'(score_m));
        check_eq("dead_frozen_food", 32'(food), 32'(food_m));

        // Async reset between edges, then placement repeats.
        segs_off();
        do_reset();
        place(1);
        check_eq("replace_food", 32'(food), 32'h25);
        check_eq("replace_score", 32'(score), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snk_food.md
# snk_food

Food placement and score keeper for the snake game. Consumes the segment vector produced by the snake core and places one food cell on a free board position. On each snake step it checks whether the head landed on the food, and maintains the 4-bit score that drives the snake core's `score` input, so snake length = score + 1. It sits directly downstream of the snake core, and its `score` output loops back upstream to that core.

## Interface
Parameters:
- `SEED`, default 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `CLK`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `snk_bits`: input, 112 bits. Flattened segments. Segment i occupies [7*i+6:7*i]:
  - bit 6 is on,
  - bits [5:3] are x,
  - bits [2:0] are y.
  - Segment 0 is the head.
- `step`: input, 1 bit. Single-cycle pulse, asserted the cycle after the snake core updates `snk_bits`.
- `dead`: input, 1 bit. Level input from the snake core.
- `food`: output, 6 bits. Food cell as {x[2:0], y[2:0]}.
- `food_valid`: output, 1 bit. `food` is placed and non-colliding.
- `score`: output, 4 bits. Segments eaten; saturates at 15.
- `eaten`: output, 1 bit. One-cycle pulse when the head is on the food.
- `win`: output, 1 bit. Sticky; set when `score` reaches 15.

## Operation
- Occupancy: cell c is occupied iff some segment i in 0..15 has bit 6 = 1 and bits [5:0] = c. The compare is combinational across all 16 segments.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shift left by one; new bit0 = q[7]^q[5]^q[4]^q[3].
  - Advances every cycle in every state except HALT.
- `cand`: 6-bit candidate register.
- FSM states are PLACE, CHECK, WAIT, HALT.
  - PLACE (one cycle): `cand` <= lfsr[5:0]; `food_valid` <= 0; go to CHECK.
  - CHECK, `cand` occupied: `cand` <= `cand`+1 (mod 64 wrap); stay in CHECK.
  - CHECK, `cand` free: `food` <= `cand`; `food_valid` <= 1; go to WAIT.
  - CHECK termination: at most 16 cells are occupied, so CHECK exits within 17 cycles.
  - WAIT: when `step`=1, segment 0 bit 6 = 1 and segment 0 [5:0] = `food`, this is an eat event:
    - `eaten` <= 1 for one cycle; `score` <= `score`+1; `food_valid` <= 0.
    - If the new score is 15: `win` <= 1 and go to HALT.
    - Otherwise go to PLACE.
  - WAIT, step with no match: no action.
  - HALT: all outputs hold. Only reset leaves HALT.
- Dead: `dead`=1 sampled in any state forces HALT on the next edge.
  - `dead` has priority over an eat event in the same cycle: no score increment, no `eaten`.
  - `food`, `food_valid` and `score` hold their values.
- Ignored steps: a `step` arriving in PLACE or CHECK is dropped, with no eat check and no queuing. The upstream step spacing must be ≥ 20 cycles.
- Score arithmetic: 4-bit unsigned and never wraps. Reaching 15 always enters HALT, so no increment past 15 occurs.

## Timing
- Reset (`rst_n`=0, asynchronous) sets:
  - state = PLACE, lfsr = `SEED`, `cand` = 0,
  - `food` = 0, `food_valid` = 0, `score` = 0, `eaten` = 0, `win` = 0.
- Reset asserted mid-CHECK or mid-WAIT aborts immediately to the reset values; the partial `cand` is discarded.
- After `rst_n` rises:
  - edge 1: PLACE loads `cand` = SEED[5:0];
  - edge 2: CHECK commits `food` if free, and `food_valid` is high after edge 2;
  - each collision adds one edge.
- Eat latency: `step` is sampled at edge N in WAIT.
  - `eaten`=1, `score` updated and `food_valid`=0 during cycle N+1.
  - PLACE occurs at edge N+1; new `food_valid` earliest after edge N+2.
- `eaten` is high for exactly one cycle per eat event.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and first placement: SEED=8'hA5, all segments off → after edge 2, `food`=6'b100101 (4,5), `food_valid`=1, `score`=0, `win`=0.
- Collision skip: segments on at (4,5), (4,6), (4,7), reset released → `food_valid` rises after edge 5 with `food`=6'b101000 (5,0); `food` never equals an occupied cell.
- Eat: in WAIT with `food`=(5,0), segment 0 = {1,101,000}, pulse `step` → next cycle `eaten`=1 for one cycle, `score` 0→1, `food_valid` 0; new food valid within 19 cycles and not equal to any on-segment.
- Non-eat and dropped step:
  - `step` with head (1,1) ≠ `food` → `score` unchanged, `food_valid` stays 1.
  - `step` pulsed during CHECK with the head on `cand` → no `eaten`.
- Saturation and win: drive 15 eat events → `score`=15, `win`=1, state HALT; a further matching `step` leaves `score`=15 and `eaten`=0.
- Dead and async reset:
  - `dead`=1 in the same cycle as a matching `step` → `score` unchanged, no `eaten`, outputs frozen.
  - `rst_n` pulsed low between clock edges → `score`=0, `win`=0, `food_valid`=0 immediately, without waiting for a clock edge; first placement repeats as in the reset scenario.
